// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Bit counter width: $clog2(width), never narrower than one bit.
    function automatic int count_width(input int width);
        if (width <= 1) begin
            return 1;
        end else begin
            return $clog2(width);
        end
    endfunction

endpackage

// File: rtl/serial_subtractor_cell.sv
// One-bit gate-level full subtractor: d = a^b^bi, bo = (~a & b) | (~(a^b) & bi).
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);
    logic w_axb;
    logic w_na;
    logic w_naxb;
    logic w_gen;
    logic w_prop;

    xor g_x1 (w_axb, a, b);
    xor g_x2 (d, w_axb, bi);
    not g_n1 (w_na, a);
    and g_a1 (w_gen, w_na, b);
    not g_n2 (w_naxb, w_axb);
    and g_a2 (w_prop, w_naxb, bi);
    or  g_o1 (bo, w_gen, w_prop);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B - Bin, LSB first, one full-subtractor cell plus a borrow flop,
// with valid/ready handshakes on operands and result.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             V
);
    localparam int            CW   = count_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_d_sr;
    logic [WIDTH-1:0] r_d;
    logic [CW-1:0]    r_count;
    logic             r_borrow;
    logic             r_bout;
    logic             r_v;
    logic             r_out_valid;

    logic             w_d;
    logic             w_bo;
    logic [WIDTH-1:0] w_d_sr_next;

    full_subtractor u_cell (
        .a  (r_a_sr[0]),
        .b  (r_b_sr[0]),
        .bi (r_borrow),
        .d  (w_d),
        .bo (w_bo)
    );

    // New difference bit enters at the MSB; written as shift/or so WIDTH=1 needs no special case.
    assign w_d_sr_next = (r_d_sr >> 1) | (WIDTH'(w_d) << (WIDTH - 1));

    // Control FSM, operand/result shift registers and held result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a_sr      <= '0;
            r_b_sr      <= '0;
            r_d_sr      <= '0;
            r_d         <= '0;
            r_count     <= '0;
            r_borrow    <= 1'b0;
            r_bout      <= 1'b0;
            r_v         <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a_sr   <= A;
                        r_b_sr   <= B;
                        r_borrow <= Bin;
                        r_count  <= '0;
                        r_state  <= RUN;
                    end else begin
                        r_state  <= IDLE;
                    end
                end
                RUN: begin
                    r_a_sr   <= r_a_sr >> 1;
                    r_b_sr   <= r_b_sr >> 1;
                    r_d_sr   <= w_d_sr_next;
                    r_borrow <= w_bo;
                    if (r_count == LAST) begin
                        r_d         <= w_d_sr_next;
                        r_bout      <= w_bo;
                        // Signs of operands differ and result sign differs from minuend.
                        r_v         <= (r_a_sr[0] != r_b_sr[0]) && (w_d != r_a_sr[0]);
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_count     <= r_count + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end else begin
                        r_state     <= DONE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = rst_n && (r_state == IDLE);
    assign out_valid = r_out_valid;
    assign D         = r_d;
    assign Bout      = r_bout;
    assign V         = r_v;

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized self-checking bench for serial_subtractor against an arithmetic reference model.
module tb_serial_subtractor;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a_s = '0;
    logic [W-1:0] b_s = '0;
    logic         bin_s = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] d_s;
    logic         bout_s;
    logic         v_s;

    int n_checks = 0;
    int n_errors = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (a_s),
        .B         (b_s),
        .Bin       (bin_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (d_s),
        .Bout      (bout_s),
        .V         (v_s)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: {V, Bout, D} from plain integer arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        int            ud;
        int            sd;
        int            sa;
        int            sb;
        logic [31:0]   ud_bits;
        logic          bo;
        logic          ov;
        ud      = int'(a) - int'(b) - int'(bin);
        ud_bits = ud;
        bo      = (ud < 0);
        sa      = $signed(a);
        sb      = $signed(b);
        sd      = sa - sb - int'(bin);
        ov      = (sd > 127) || (sd < -128);
        return {ov, bo, ud_bits[W-1:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        check_value("in_ready_before_accept", in_ready, 1);
        in_valid = 1'b1;
        a_s      = a;
        b_s      = b;
        bin_s    = bin;
        tick();
        in_valid = 1'b0;
        a_s      = W'($urandom);
        b_s      = W'($urandom);
        bin_s    = 1'($urandom);
        check_value("in_ready_in_run", in_ready, 0);
    endtask

    task automatic wait_result(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        logic [W+1:0] exp;
        int           edges;
        edges = 0;
        while (!out_valid && edges < W + 6) begin
            tick();
            edges++;
        end
        check_value("latency", edges, W);
        exp = model(a, b, bin);
        check_value("out_valid", out_valid, 1);
        check_value("D", d_s, exp[W-1:0]);
        check_value("Bout", bout_s, exp[W]);
        check_value("V", v_s, exp[W+1]);
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_value("out_valid_after_release", out_valid, 0);
        check_value("in_ready_after_release", in_ready, 1);
    endtask

    task automatic full_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        accept(a, b, bin);
        wait_result(a, b, bin);
        release_result();
    endtask

    initial begin
        logic [W+1:0] held;
        int           seen;

        repeat (3) tick();
        check_value("rst_in_ready", in_ready, 0);
        check_value("rst_out_valid", out_valid, 0);
        check_value("rst_D", d_s, 0);
        check_value("rst_Bout", bout_s, 0);
        check_value("rst_V", v_s, 0);
        rst_n = 1'b1;
        #1;
        check_value("post_rst_in_ready", in_ready, 1);
        tick();

        full_op(8'h05, 8'h03, 1'b0);
        full_op(8'h03, 8'h05, 1'b0);
        full_op(8'h80, 8'h01, 1'b0);
        full_op(8'h7F, 8'hFF, 1'b0);
        full_op(8'h00, 8'h00, 1'b1);
        full_op(8'hFF, 8'hFF, 1'b1);
        full_op(8'h80, 8'h00, 1'b1);

        // Backpressure with a competing operand offer in DONE.
        accept(8'h5A, 8'h33, 1'b0);
        wait_result(8'h5A, 8'h33, 1'b0);
        held     = {v_s, bout_s, d_s};
        in_valid = 1'b1;
        a_s      = 8'hC3;
        b_s      = 8'h11;
        bin_s    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_value("bp_out_valid", out_valid, 1);
            check_value("bp_in_ready", in_ready, 0);
            check_value("bp_held", {v_s, bout_s, d_s}, held);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_value("bp_release_valid", out_valid, 0);
        check_value("bp_release_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check_value("bp_accept_in_ready", in_ready, 0);
        wait_result(8'hC3, 8'h11, 1'b1);
        release_result();

        // Reset asserted at the third RUN edge.
        accept(8'h44, 8'h22, 1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check_value("mid_rst_out_valid", out_valid, 0);
        check_value("mid_rst_in_ready", in_ready, 0);
        check_value("mid_rst_D", d_s, 0);
        check_value("mid_rst_Bout", bout_s, 0);
        check_value("mid_rst_V", v_s, 0);
        tick();
        rst_n = 1'b1;
        #1;
        check_value("mid_rst_release_ready", in_ready, 1);
        seen = 0;
        for (int i = 0; i < W + 4; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check_value("mid_rst_no_valid", seen, 0);
        full_op(8'h10, 8'h01, 1'b0);

        // Randomized operations with random idle gaps and DONE hold times.
        for (int n = 0; n < 40; n++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rbin;
            ra   = W'($urandom);
            rb   = W'($urandom);
            rbin = 1'($urandom);
            repeat ($urandom_range(0, 2)) tick();
            accept(ra, rb, rbin);
            wait_result(ra, rb, rbin);
            held = {v_s, bout_s, d_s};
            repeat ($urandom_range(0, 3)) begin
                out_ready = 1'b0;
                tick();
                check_value("rand_hold", {v_s, bout_s, d_s}, held);
            end
            release_result();
            check_value("rand_keep_after_release", {v_s, bout_s, d_s}, held);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
